// File: rtl/dds_cmd_pkg.sv
// Shared constants and state encoding for the DDS command controller.
package dds_cmd_pkg;

  // Frame header byte
  localparam logic [7:0] HDR = 8'h55;

  // Command codes
  localparam logic [7:0] CMD_SET_FWORD = 8'h01;
  localparam logic [7:0] CMD_SET_PWORD = 8'h02;
  localparam logic [7:0] CMD_SET_MODE  = 8'h03;
  localparam logic [7:0] CMD_APPLY     = 8'h04;

  // Response codes
  localparam logic [7:0] RESP_OK     = 8'hAA;
  localparam logic [7:0] RESP_CSUM   = 8'hEE;
  localparam logic [7:0] RESP_BADCMD = 8'hEC;
  localparam logic [7:0] RESP_TMO    = 8'hE7;

  // Frame parser states
  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StCsum
  } state_e;

endpackage

// File: rtl/dds_cmd_ctrl.sv
// Byte-stream command controller: parses 7-byte frames, stages values in
// shadow registers and commits them to the DDS inputs atomically on APPLY.
module dds_cmd_ctrl
  import dds_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [31:0] FWORD_RST      = 32'h00A00000,
  parameter logic [11:0] PWORD_RST      = 12'h000,
  parameter logic [1:0]  MODE_RST       = 2'b00
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [1:0]  Mode_Sel,
  output logic [31:0] Fword,
  output logic [11:0] Pword,
  output logic        cfg_update,
  output logic        resp_valid,
  output logic [7:0]  resp_code
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   shadow_f_q, shadow_f_d;
  logic [11:0]   shadow_p_q, shadow_p_d;
  logic [1:0]    shadow_m_q, shadow_m_d;
  logic [31:0]   active_f_q, active_f_d;
  logic [11:0]   active_p_q, active_p_d;
  logic [1:0]    active_m_q, active_m_d;
  logic          cfg_update_q, cfg_update_d;
  logic          resp_valid_q, resp_valid_d;
  logic [7:0]    resp_code_q, resp_code_d;
  logic          timeout;

  // Next-state logic: frame parsing, execution, response and inter-byte timeout
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    csum_d       = csum_q;
    cmd_d        = cmd_q;
    data_d       = data_q;
    shadow_f_d   = shadow_f_q;
    shadow_p_d   = shadow_p_q;
    shadow_m_d   = shadow_m_q;
    active_f_d   = active_f_q;
    active_p_d   = active_p_q;
    active_m_d   = active_m_q;
    cfg_update_d = 1'b0;
    resp_valid_d = 1'b0;
    resp_code_d  = resp_code_q;
    timeout      = 1'b0;

    // A byte arriving on the expiry cycle wins over the timeout
    if (state_q == StIdle || rx_done) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TMO_LAST) begin
      tmo_cnt_d = '0;
      timeout   = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    case (state_q)
      StIdle: begin
        if (rx_done && rx_data == HDR) state_d = StCmd;
      end
      StCmd: begin
        if (rx_done) begin
          cmd_d      = rx_data;
          csum_d     = rx_data;
          byte_cnt_d = 2'd0;
          state_d    = StData;
        end
      end
      StData: begin
        if (rx_done) begin
          data_d     = {data_q[23:0], rx_data};
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StCsum;
        end
      end
      StCsum: begin
        if (rx_done) begin
          state_d      = StIdle;
          resp_valid_d = 1'b1;
          if (rx_data != csum_q) begin
            resp_code_d = RESP_CSUM;
          end else begin
            resp_code_d = RESP_OK;
            case (cmd_q)
              CMD_SET_FWORD: shadow_f_d = data_q;
              CMD_SET_PWORD: shadow_p_d = data_q[11:0];
              CMD_SET_MODE:  shadow_m_d = data_q[1:0];
              CMD_APPLY: begin
                active_f_d   = shadow_f_q;
                active_p_d   = shadow_p_q;
                active_m_d   = shadow_m_q;
                cfg_update_d = 1'b1;
              end
              default:       resp_code_d = RESP_BADCMD;
            endcase
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d      = StIdle;
      resp_valid_d = 1'b1;
      resp_code_d  = RESP_TMO;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= StIdle;
      byte_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      csum_q       <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      shadow_f_q   <= FWORD_RST;
      shadow_p_q   <= PWORD_RST;
      shadow_m_q   <= MODE_RST;
      active_f_q   <= FWORD_RST;
      active_p_q   <= PWORD_RST;
      active_m_q   <= MODE_RST;
      cfg_update_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      csum_q       <= csum_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      shadow_f_q   <= shadow_f_d;
      shadow_p_q   <= shadow_p_d;
      shadow_m_q   <= shadow_m_d;
      active_f_q   <= active_f_d;
      active_p_q   <= active_p_d;
      active_m_q   <= active_m_d;
      cfg_update_q <= cfg_update_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
    end
  end

  assign Fword      = active_f_q;
  assign Pword      = active_p_q;
  assign Mode_Sel   = active_m_q;
  assign cfg_update = cfg_update_q;
  assign resp_valid = resp_valid_q;
  assign resp_code  = resp_code_q;

endmodule
